run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Top-level run controller for the 9-bit-instruction core.
- Accepts a level request from the bench or host and holds the core in reset for a fixed number of cycles.
- Releases the core, counts execution cycles and detects program end (halt or PC past the end address). It then stalls the core, drains the last memory write and reports done/timeout over a 4-phase handshake.
- Sits between the bench/host and the core's reset and clock-enable inputs, replacing ad-hoc done logic based on a PC compare.

Parameters:
D, 12, program counter width (matches PC)
END_PC, 710, run ends when prog_ctr > END_PC
RST_CYC, 2, cycles core_rst is held in INIT (>=1)
DRAIN_CYC, 2, cycles core is stalled before done (>=1)
CW, 16, cycle counter width
MAX_CYC, 4095, RUN-cycle limit before timeout (< 2**CW)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  run request; level, 4-phase with done
abort  in  1  synchronous abort, highest priority
halt  in  1  halt decode from control, sampled only in RUN
prog_ctr  in  D  current PC from fetch unit
core_rst  out  1  active-high reset to core (PC, flags)
core_en  out  1  core clock enable / advance
busy  out  1  high in INIT, RUN and DRAIN
done  out  1  high in DONE
timeout  out  1  run ended by MAX_CYC; valid while done=1
cycle_cnt  out  CW  RUN cycles of the current or last run

Behaviour:
- Reset (reset=0, async): state=IDLE, core_rst=1, core_en=0, busy=0, done=0, timeout=0, cycle_cnt=0.
- States: IDLE, INIT, RUN, DRAIN, DONE. All outputs are registered or a pure decode of state. No combinational path from input to output.
- IDLE
  - Outputs: core_rst=1, core_en=0.
  - req=1 -> INIT next edge. On that edge: cycle_cnt<=0, timeout<=0, sub-counter<=0.
- INIT
  - Outputs: core_rst=1, core_en=0.
  - Stays exactly RST_CYC cycles, then -> RUN.
- RUN
  - Outputs: core_rst=0, core_en=1.
  - cycle_cnt increments every RUN cycle and saturates at MAX_CYC.
  - End check is evaluated each RUN cycle on current inputs:
    - halt=1 or prog_ctr>END_PC (unsigned) -> DRAIN, timeout stays 0.
    - Otherwise, cycle_cnt==MAX_CYC -> DRAIN, timeout<=1.
    - Normal end has priority over timeout in the same cycle.
  - The end cycle itself is counted.
- DRAIN
  - Outputs: core_rst=0, core_en=0. Core state is frozen so the final store commits.
  - Stays exactly DRAIN_CYC cycles, then -> DONE.
- DONE
  - Outputs: done=1, core_rst=0, core_en=0. cycle_cnt and timeout are held.
  - req=0 -> IDLE. req held high -> remain in DONE; no auto-restart.
- abort=1 in any state -> IDLE next edge. cycle_cnt is held, timeout<=0, done drops. Abort takes priority over every other transition. Abort in IDLE has no effect.
- req dropped during INIT/RUN/DRAIN is ignored; the run completes.
- Reset asserted mid-run forces IDLE values asynchronously. Outputs reach their reset values immediately, not at the next edge.
- Width rules: the prog_ctr compare is D-bit unsigned. The sub-counter is $clog2(max(RST_CYC,DRAIN_CYC)+1) bits and is cleared on every state change.
- Latencies:
  - req rise to core_en=1 is RST_CYC+1 edges.
  - End condition to done=1 is DRAIN_CYC+1 edges.
  - done fall follows req fall by 1 edge.

Decomposition:
- Shared package jay_pkg holds:
  - typedef enum logic [2:0] run_state_t {IDLE, INIT, RUN, DRAIN, DONE}
  - localparams for default END_PC and MAX_CYC, used by this block and the testbench.
- One sub-module, sat_counter #(W, MAX): provides clear, enable, saturating count and an at_max flag.
  - Instantiated for cycle_cnt.
  - Also instantiated for the INIT/DRAIN phase counter.
- FSM next-state and output decode stay in run_sequencer.

Test Plan:
- Normal run, defaults: reset release, req=1, prog_ctr ramps 0->711 one per cycle.
  - core_en rises 3 edges after req.
  - done=1 3 edges after prog_ctr=711 is seen.
  - cycle_cnt=712, timeout=0.
- Halt: halt=1 on RUN cycle 5 with prog_ctr=4 -> DRAIN, done after 3 edges, cycle_cnt=5, timeout=0.
- Timeout: MAX_CYC=15, prog_ctr held at 0, halt=0 -> cycle_cnt saturates at 15, timeout=1, done=1. Dropping req returns to IDLE and core_rst=1.
- Simultaneous end: MAX_CYC=15 and prog_ctr=711 on the 15th RUN cycle -> timeout=0, cycle_cnt=15.
- Abort and reset mid-run:
  - abort=1 on RUN cycle 7 -> IDLE next edge, core_rst=1, done never asserts, cycle_cnt=7.
  - Repeat the run with async reset=0 mid-cycle -> all outputs take reset values before the next clk edge.
- Handshake: req held high after done -> stays DONE 10 cycles with no restart. req low then high -> a new run with cycle_cnt cleared to 0 in INIT.

Source files
------------

// File: rtl/jay_pkg.sv
// Shared types and defaults for the run sequencer and anything that drives it.
package jay_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } run_state_t;

  localparam int DEF_END_PC  = 710;
  localparam int DEF_MAX_CYC = 4095;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Host-side control and status bundle of the run sequencer.
interface run_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);

  logic          req;
  logic          abort;
  logic          halt;
  logic [D-1:0]  prog_ctr;
  logic          core_rst;
  logic          core_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output req, abort, halt, prog_ctr,
    input  core_rst, core_en, busy, done, timeout, cycle_cnt
  );

  modport slave (
    input  req, abort, halt, prog_ctr,
    output core_rst, core_en, busy, done, timeout, cycle_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear, count enable and saturation at MAX.
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         atMax_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign atMax_o = (cnt_q == MAX_V);

endmodule

// File: rtl/run_sequencer.sv
// Run controller: holds the core in reset, runs it until halt/PC end/timeout,
// stalls it to let the last store land, then reports done over a 4-phase req/done handshake.
module run_sequencer
  import jay_pkg::*;
#(
  parameter int D         = 12,
  parameter int END_PC    = DEF_END_PC,
  parameter int RST_CYC   = 2,
  parameter int DRAIN_CYC = 2,
  parameter int CW        = 16,
  parameter int MAX_CYC   = DEF_MAX_CYC
) (
  input  logic           clk,
  input  logic           reset,
  run_sequencer_if.slave bus
);

  localparam int PHASE_MAX = maxInt(RST_CYC, DRAIN_CYC);
  localparam int PW        = $clog2(PHASE_MAX + 1);

  localparam logic [D-1:0]  END_V      = D'(END_PC);
  localparam logic [PW-1:0] INIT_LAST  = PW'(RST_CYC - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(MAX_CYC - 1);

  run_state_t    state_q;
  run_state_t    state_d;
  logic          timeout_q;
  logic          timeout_d;
  logic [PW-1:0] phaseCnt;
  logic          phaseAtMax;
  logic [CW-1:0] cycleCnt;
  logic          cycleAtMax;
  logic          normalEnd;
  logic          cycleHit;
  logic          phaseDone;

  assign normalEnd = bus.halt || (bus.prog_ctr > END_V);
  // The limit trips on the RUN cycle whose own count brings cycle_cnt to MAX_CYC.
  assign cycleHit  = cycleAtMax || (cycleCnt == CYC_LAST);
  assign phaseDone = phaseAtMax ||
                     (phaseCnt == ((state_q == INIT) ? INIT_LAST : DRAIN_LAST));

  sat_counter #(.W(PW), .MAX(PHASE_MAX)) phaseCounter (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (state_d != state_q),
    .en_i    ((state_q == INIT) || (state_q == DRAIN)),
    .cnt_o   (phaseCnt),
    .atMax_o (phaseAtMax)
  );

  sat_counter #(.W(CW), .MAX(MAX_CYC)) cycleCounter (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   ((state_q == IDLE) && (state_d == INIT)),
    .en_i    (state_q == RUN),
    .cnt_o   (cycleCnt),
    .atMax_o (cycleAtMax)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req)               state_d = INIT;
      INIT:    if (phaseDone)             state_d = RUN;
      RUN:     if (normalEnd || cycleHit) state_d = DRAIN;
      DRAIN:   if (phaseDone)             state_d = DONE;
      DONE:    if (!bus.req)              state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if ((state_q == IDLE) && (state_d == INIT)) begin
      timeout_d = 1'b0;
    end else if ((state_q == RUN) && !normalEnd && cycleHit) begin
      timeout_d = 1'b1;
    end
    if (bus.abort && (state_q != IDLE)) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.core_rst  = (state_q == IDLE) || (state_q == INIT);
  assign bus.core_en   = (state_q == RUN);
  assign bus.busy      = (state_q == INIT) || (state_q == RUN) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.timeout   = timeout_q;
  assign bus.cycle_cnt = cycleCnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer: two instances (default limit and a short
// 15-cycle limit) share stimulus and are checked every cycle against a phase-timeline model.
module tb_run_sequencer;
  import jay_pkg::*;

  localparam int RST_CYC   = 2;
  localparam int DRAIN_CYC = 2;
  localparam int END_PC    = DEF_END_PC;
  localparam int MAX_A     = DEF_MAX_CYC;
  localparam int MAX_B     = 15;
  localparam int NEVER     = 1 << 30;

  logic clock = 1'b0;
  logic reset;
  int   compareCount = 0;
  int   mismatchCount = 0;
  int   scenarioId = 0;

  int pcMode;
  int pcVal;
  int haltK;

  always #5 clock = ~clock;

  run_sequencer_if #(.D(12), .CW(16)) busA ();
  run_sequencer_if #(.D(12), .CW(16)) busB ();

  assign busB.req      = busA.req;
  assign busB.abort    = busA.abort;
  assign busB.halt     = busA.halt;
  assign busB.prog_ctr = busA.prog_ctr;

  run_sequencer #(.MAX_CYC(MAX_A)) dutA (.clk(clock), .reset(reset), .bus(busA));
  run_sequencer #(.MAX_CYC(MAX_B)) dutB (.clk(clock), .reset(reset), .bus(busB));

  logic [31:0] obsA;
  logic [31:0] obsB;
  assign obsA = {11'd0, busA.core_rst, busA.core_en, busA.busy, busA.done, busA.timeout, busA.cycle_cnt};
  assign obsB = {11'd0, busB.core_rst, busB.core_en, busB.busy, busB.done, busB.timeout, busB.cycle_cnt};

  // Status word layout: {core_rst, core_en, busy, done, timeout, cycle_cnt}.
  function automatic logic [31:0] packStatus(input bit r, input bit e, input bit b,
                                             input bit d, input bit t, input int c);
    return {11'd0, r, e, b, d, t, 16'(c)};
  endfunction

  function automatic logic [11:0] pcAt(input int k);
    return (pcMode != 0) ? 12'(pcVal + k - 1) : 12'(pcVal);
  endfunction

  // First RUN cycle (1-based) on which halt or PC-past-end is presented.
  function automatic int firstEnd();
    for (int k = 1; k <= 5000; k++) begin
      if ((k == haltK) || (int'(pcAt(k)) > END_PC)) return k;
    end
    return NEVER;
  endfunction

  // Expected status after edge n counted from the edge that sees req rise.
  function automatic logic [31:0] expStatus(input int n, input int endK, input bit to);
    if (n <= RST_CYC)                        return packStatus(1, 0, 1, 0, 0, 0);
    if (n <= RST_CYC + endK)                 return packStatus(0, 1, 1, 0, 0, n - RST_CYC - 1);
    if (n <= RST_CYC + endK + DRAIN_CYC)     return packStatus(0, 0, 1, 0, to, endK);
    return packStatus(0, 0, 0, 1, to, endK);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s (scenario %0d, t=%0t): observed %h, expected %h",
               tag, scenarioId, $time, observed, expected);
    end
  endtask

  task automatic junkInputs();
    busA.halt     = 1'($urandom);
    busA.prog_ctr = 12'($urandom);
  endtask

  // One run: mode 0 = constant PC, 1 = ramp; hK = halt cycle (0 none);
  // abortK > 0 aborts on that RUN cycle, < 0 picks one at random; endByAbort leaves DONE by abort.
  task automatic applyStimulus(input int mode, input int val, input int hK,
                               input int abortK, input bit endByAbort);
    int  kN, endA, endB, lastN, k, abK;
    bit  toA, toB, glitch;
    logic [31:0] idleA, idleB;
    scenarioId++;
    pcMode = mode;
    pcVal  = val;
    haltK  = hK;
    kN     = firstEnd();
    endA   = (kN < MAX_A) ? kN : MAX_A;
    endB   = (kN < MAX_B) ? kN : MAX_B;
    toA    = (kN > MAX_A);
    toB    = (kN > MAX_B);
    abK    = (abortK < 0) ? int'($urandom_range(endB, 1)) : abortK;
    glitch = 1'($urandom);
    lastN  = (abK > 0) ? (RST_CYC + abK) : (RST_CYC + endA + DRAIN_CYC + 1 + 10);

    busA.req = 1'b1;
    junkInputs();
    for (int n = 1; n <= lastN; n++) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput("runA", obsA, expStatus(n, endA, toA));
      checkOutput("runB", obsB, expStatus(n, endB, toB));
      busA.req = !(glitch && (n == 1));
      k = n - RST_CYC;
      if ((k >= 1) && (k <= endA)) begin
        busA.halt     = (k == haltK);
        busA.prog_ctr = pcAt(k);
      end else begin
        junkInputs();
      end
      if ((abK > 0) && (n == lastN)) begin
        busA.abort = 1'b1;
        busA.req   = 1'b0;
      end
    end

    if (abK == 0) begin
      busA.abort = endByAbort;
      busA.req   = 1'b0;
    end
    if (abK > 0) begin
      idleA = packStatus(1, 0, 0, 0, 0, abK);
      idleB = packStatus(1, 0, 0, 0, 0, abK);
    end else begin
      idleA = packStatus(1, 0, 0, 0, endByAbort ? 1'b0 : toA, endA);
      idleB = packStatus(1, 0, 0, 0, endByAbort ? 1'b0 : toB, endB);
    end

    @(posedge clock);
    @(negedge clock);
    busA.abort = 1'b0;
    checkOutput("idleA", obsA, idleA);
    checkOutput("idleB", obsB, idleB);
    busA.abort = 1'($urandom);
    junkInputs();
    @(posedge clock);
    @(negedge clock);
    busA.abort = 1'b0;
    checkOutput("holdA", obsA, idleA);
    checkOutput("holdB", obsB, idleB);
  endtask

  task automatic resetMidRun();
    scenarioId++;
    pcMode = 0;
    pcVal  = 0;
    haltK  = 0;
    busA.req      = 1'b1;
    busA.halt     = 1'b0;
    busA.prog_ctr = 12'd0;
    repeat (RST_CYC + 4) @(negedge clock);
    checkOutput("preRstA", obsA, expStatus(RST_CYC + 4, MAX_A, 1'b1));
    checkOutput("preRstB", obsB, expStatus(RST_CYC + 4, MAX_B, 1'b1));
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncRstA", obsA, packStatus(1, 0, 0, 0, 0, 0));
    checkOutput("asyncRstB", obsB, packStatus(1, 0, 0, 0, 0, 0));
    busA.req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("postRstA", obsA, packStatus(1, 0, 0, 0, 0, 0));
    checkOutput("postRstB", obsB, packStatus(1, 0, 0, 0, 0, 0));
  endtask

  initial begin
    int mode, val, hK, abK;
    reset         = 1'b0;
    busA.req      = 1'b0;
    busA.abort    = 1'b0;
    busA.halt     = 1'b0;
    busA.prog_ctr = 12'd0;
    #1;
    checkOutput("resetA", obsA, packStatus(1, 0, 0, 0, 0, 0));
    checkOutput("resetB", obsB, packStatus(1, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clock);
    reset = 1'b1;

    applyStimulus(1, 0, 0, 0, 1'b0);
    applyStimulus(0, 4, 5, 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(1, 697, 0, 0, 1'b1);
    applyStimulus(0, 0, 0, 7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(1, 0));
      if (mode != 0) begin
        val = int'($urandom_range(711, 680));
        hK  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(40, 1)) : 0;
      end else if ($urandom_range(3, 0) == 0) begin
        val = int'($urandom_range(4095, 711));
        hK  = int'($urandom_range(5, 0));
      end else begin
        val = int'($urandom_range(710, 0));
        hK  = int'($urandom_range(40, 1));
      end
      abK = ($urandom_range(3, 0) == 0) ? -1 : 0;
      applyStimulus(mode, val, hK, abK, 1'($urandom));
    end

    resetMidRun();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
